// File: rtl/bx_phase_tracker.sv
// rtl/bx_phase_tracker.sv - 160 MHz phase tracker locking to a sampled 40 MHz LHC clock
// Optional BX counter with orbit reset (bc0) is compiled in by defining BX_COUNTER_EN.
module bx_phase_tracker #(
  parameter int unsigned LOCK_COUNT = 16,
  parameter int unsigned MAX_BX     = 3563
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clock40_sample,
  input  logic        bc0,
  output logic [1:0]  phase,
  output logic        frame_strobe,
  output logic        locked,
  output logic [7:0]  lock_errors
`ifdef BX_COUNTER_EN
  ,
  output logic [11:0] bx_count
`endif
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        s1_q, s2_q, s3_q;
  logic [1:0]  phase_q, phase_d;
  logic [7:0]  good_cnt_q, good_cnt_d;
  logic [7:0]  lock_errors_q, lock_errors_d;
  logic        locked_q, locked_d;
  logic        frame_strobe_q, frame_strobe_d;
  logic        rise;
  logic        phase_last;
  logic        good;
  logic        err;

  always_comb begin
    rise       = s2_q & ~s3_q;
    phase_last = (phase_q == 2'd3);
    good       = rise & phase_last;
    // An edge off phase 3, or phase 3 without an edge, are both errors.
    err        = rise ^ phase_last;
    phase_d    = rise ? 2'd0 : phase_q + 2'd1;

    state_d       = state_q;
    good_cnt_d    = good_cnt_q;
    lock_errors_d = lock_errors_q;
    case (state_q)
      UNLOCKED: begin
        if (rise) begin
          state_d    = ACQUIRE;
          good_cnt_d = 8'd0;
        end
      end
      ACQUIRE: begin
        if (err) begin
          state_d = UNLOCKED;
        end else if (good) begin
          good_cnt_d = good_cnt_q + 8'd1;
          if (good_cnt_q == 8'(LOCK_COUNT - 2)) state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (err) begin
          state_d = UNLOCKED;
          if (lock_errors_q != 8'd255) lock_errors_d = lock_errors_q + 8'd1;
        end
      end
      default: state_d = UNLOCKED;
    endcase

    locked_d       = (state_d == LOCKED);
    frame_strobe_d = locked_d && (phase_d == 2'd0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      s3_q           <= 1'b0;
      phase_q        <= 2'd0;
      state_q        <= UNLOCKED;
      good_cnt_q     <= 8'd0;
      lock_errors_q  <= 8'd0;
      locked_q       <= 1'b0;
      frame_strobe_q <= 1'b0;
    end else begin
      s1_q           <= clock40_sample;
      s2_q           <= s1_q;
      s3_q           <= s2_q;
      phase_q        <= phase_d;
      state_q        <= state_d;
      good_cnt_q     <= good_cnt_d;
      lock_errors_q  <= lock_errors_d;
      locked_q       <= locked_d;
      frame_strobe_q <= frame_strobe_d;
    end
  end

  assign phase        = phase_q;
  assign frame_strobe = frame_strobe_q;
  assign locked       = locked_q;
  assign lock_errors  = lock_errors_q;

`ifdef BX_COUNTER_EN
  logic        bc0_pend_q, bc0_pend_d;
  logic [11:0] bx_q, bx_d;
  logic        boundary;

  // bc0 arriving on the boundary cycle is applied there and never pends.
  always_comb begin
    boundary   = locked_q && (phase_q == 2'd3);
    bc0_pend_d = bc0_pend_q;
    bx_d       = bx_q;
    if (boundary) begin
      bc0_pend_d = 1'b0;
      if (bc0 || bc0_pend_q)        bx_d = 12'd0;
      else if (bx_q == 12'(MAX_BX)) bx_d = 12'd0;
      else                          bx_d = bx_q + 12'd1;
    end else if (bc0) begin
      bc0_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bc0_pend_q <= 1'b0;
      bx_q       <= 12'd0;
    end else begin
      bc0_pend_q <= bc0_pend_d;
      bx_q       <= bx_d;
    end
  end

  assign bx_count = bx_q;
`else
  logic unused_bc0;
  assign unused_bc0 = bc0;
`endif

endmodule

// File: tb/tb_bx_phase_tracker.sv
// tb/tb_bx_phase_tracker.sv - directed self-checking bench for bx_phase_tracker
module tb_bx_phase_tracker;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        clock40_sample = 1'b0;
  logic        bc0 = 1'b0;
  logic [1:0]  phase;
  logic        frame_strobe;
  logic        locked;
  logic [7:0]  lock_errors;
`ifdef BX_COUNTER_EN
  logic [11:0] bx_count;
`endif

  int vectors = 0;
  int miscompares = 0;
  int c40_ph = 0;

  bx_phase_tracker #(.LOCK_COUNT(16), .MAX_BX(3563)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .clock40_sample (clock40_sample),
    .bc0            (bc0),
    .phase          (phase),
    .frame_strobe   (frame_strobe),
    .locked         (locked),
    .lock_errors    (lock_errors)
`ifdef BX_COUNTER_EN
    ,
    .bx_count       (bx_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick(input logic v);
    clock40_sample = v;
    @(posedge clock);
    #1;
  endtask

  // Clean 40 MHz: high two fast cycles, low two.
  task automatic tick_clean();
    tick(c40_ph < 2);
    c40_ph = (c40_ph + 1) % 4;
  endtask

  task automatic align_rise();
    while (c40_ph != 0) tick_clean();
  endtask

  task automatic run_until_locked(output int n);
    n = 0;
    while (!locked && n < 200) begin
      tick_clean();
      n++;
    end
  endtask

`ifdef BX_COUNTER_EN
  task automatic wait_strobe(output logic ok);
    int k;
    k = 0;
    ok = 1'b0;
    while (k < 8 && !ok) begin
      tick_clean();
      k++;
      ok = frame_strobe;
    end
  endtask
`endif

  task automatic test_reset();
    reset_n = 1'b0;
    clock40_sample = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked: got %0d expected 0", locked); end
    vectors++; if (frame_strobe !== 1'b0) begin miscompares++; $display("FAIL reset_strobe: got %0d expected 0", frame_strobe); end
    vectors++; if (phase !== 2'd0) begin miscompares++; $display("FAIL reset_phase: got %0d expected 0", phase); end
    vectors++; if (lock_errors !== 8'd0) begin miscompares++; $display("FAIL reset_errors: got %0d expected 0", lock_errors); end
`ifdef BX_COUNTER_EN
    vectors++; if (bx_count !== 12'd0) begin miscompares++; $display("FAIL reset_bx: got %0d expected 0", bx_count); end
`endif
    reset_n = 1'b1;
    c40_ph = 0;
  endtask

  task automatic test_clean_lock();
    int n;
    int exp_ph;
    run_until_locked(n);
    vectors++; if (n !== 63) begin miscompares++; $display("FAIL lock_latency: got %0d ticks expected 63", n); end
    vectors++; if (lock_errors !== 8'd0) begin miscompares++; $display("FAIL lock_errors_clean: got %0d expected 0", lock_errors); end
    vectors++; if (phase !== 2'd0 || frame_strobe !== 1'b1) begin miscompares++; $display("FAIL lock_first_strobe: got phase %0d strobe %0d expected 0 1", phase, frame_strobe); end
    exp_ph = 0;
    for (int i = 0; i < 40; i++) begin
      tick_clean();
      exp_ph = (exp_ph + 1) % 4;
      vectors++;
      if (phase !== 2'(exp_ph) || frame_strobe !== (exp_ph == 0) || locked !== 1'b1) begin
        miscompares++;
        $display("FAIL strobe_cadence: tick %0d got phase %0d strobe %0d locked %0d expected %0d %0d 1", i, phase, frame_strobe, locked, exp_ph, exp_ph == 0);
      end
    end
  endtask

  task automatic test_delayed_edge();
    int n;
    align_rise();
    tick(1'b0);
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL delay_pre: got locked %0d expected 1", locked); end
    tick_clean();
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL delay_hold: got locked %0d expected 1", locked); end
    tick_clean();
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL delay_unlock: got locked %0d expected 0", locked); end
    vectors++; if (lock_errors !== 8'd1) begin miscompares++; $display("FAIL delay_errors: got %0d expected 1", lock_errors); end
    run_until_locked(n);
    vectors++; if (n !== 61) begin miscompares++; $display("FAIL delay_relock: got %0d ticks expected 61", n); end
    vectors++; if (lock_errors !== 8'd1) begin miscompares++; $display("FAIL delay_errors_after: got %0d expected 1", lock_errors); end
  endtask

  task automatic test_dropout();
    int n;
    align_rise();
    for (int i = 0; i < 10; i++) begin
      tick(1'b0);
      if (i == 1) begin
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL drop_hold: got locked %0d expected 1", locked); end
      end
      if (i == 2) begin
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL drop_unlock: got locked %0d expected 0", locked); end
      end
    end
    vectors++; if (lock_errors !== 8'd2) begin miscompares++; $display("FAIL drop_errors: got %0d expected 2", lock_errors); end
    run_until_locked(n);
    vectors++; if (n !== 63) begin miscompares++; $display("FAIL drop_relock: got %0d ticks expected 63", n); end
    vectors++; if (lock_errors !== 8'd2) begin miscompares++; $display("FAIL drop_errors_after: got %0d expected 2", lock_errors); end
  endtask

`ifdef BX_COUNTER_EN
  task automatic test_bx_counter();
    logic ok;
    logic seq_ok;
    int k;
    int exp_bx;
    k = 0;
    while (phase != 2'd1 && k < 8) begin tick_clean(); k++; end
    bc0 = 1'b1;
    tick_clean();
    bc0 = 1'b0;
    wait_strobe(ok);
    vectors++; if (!ok || bx_count !== 12'd0) begin miscompares++; $display("FAIL bx_bc0_mid: got %0d strobe %0d expected 0", bx_count, ok); end
    exp_bx = 0;
    seq_ok = 1'b1;
    for (int s = 1; s <= 3564; s++) begin
      wait_strobe(ok);
      exp_bx = (exp_bx == 3563) ? 0 : exp_bx + 1;
      if (!ok || bx_count !== 12'(exp_bx)) seq_ok = 1'b0;
      if (s == 3563) begin
        vectors++; if (bx_count !== 12'd3563) begin miscompares++; $display("FAIL bx_max: got %0d expected 3563", bx_count); end
      end
      if (s == 3564) begin
        vectors++; if (bx_count !== 12'd0) begin miscompares++; $display("FAIL bx_wrap: got %0d expected 0", bx_count); end
      end
    end
    vectors++; if (seq_ok !== 1'b1) begin miscompares++; $display("FAIL bx_sequence: got %0d expected 1", seq_ok); end
    k = 0;
    while (phase != 2'd3 && k < 8) begin tick_clean(); k++; end
    bc0 = 1'b1;
    tick_clean();
    bc0 = 1'b0;
    vectors++; if (frame_strobe !== 1'b1 || bx_count !== 12'd0) begin miscompares++; $display("FAIL bx_bc0_boundary: got %0d strobe %0d expected 0 1", bx_count, frame_strobe); end
    wait_strobe(ok);
    vectors++; if (!ok || bx_count !== 12'd1) begin miscompares++; $display("FAIL bx_no_pending: got %0d expected 1", bx_count); end
    for (int s = 0; s < 99; s++) wait_strobe(ok);
    vectors++; if (bx_count !== 12'd100) begin miscompares++; $display("FAIL bx_reach_100: got %0d expected 100", bx_count); end
  endtask
`endif

  task automatic test_reset_mid_lock();
    int n;
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL rst_pre_locked: got %0d expected 1", locked); end
    reset_n = 1'b0;
    clock40_sample = 1'b0;
    #2;
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL rst_async_locked: got %0d expected 0", locked); end
    vectors++; if (frame_strobe !== 1'b0) begin miscompares++; $display("FAIL rst_async_strobe: got %0d expected 0", frame_strobe); end
    vectors++; if (lock_errors !== 8'd0) begin miscompares++; $display("FAIL rst_async_errors: got %0d expected 0", lock_errors); end
    vectors++; if (phase !== 2'd0) begin miscompares++; $display("FAIL rst_async_phase: got %0d expected 0", phase); end
`ifdef BX_COUNTER_EN
    vectors++; if (bx_count !== 12'd0) begin miscompares++; $display("FAIL rst_async_bx: got %0d expected 0", bx_count); end
`endif
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    c40_ph = 0;
    run_until_locked(n);
    vectors++; if (n !== 63) begin miscompares++; $display("FAIL rst_relock: got %0d ticks expected 63", n); end
  endtask

  task automatic test_saturation();
    int n;
    int exp_err;
    exp_err = 0;
    for (int i = 0; i < 300; i++) begin
      align_rise();
      tick(1'b0);
      tick_clean();
      tick_clean();
      exp_err = (exp_err < 255) ? exp_err + 1 : 255;
      vectors++; if (lock_errors !== 8'(exp_err)) begin miscompares++; $display("FAIL sat_errors: loss %0d got %0d expected %0d", i, lock_errors, exp_err); end
      run_until_locked(n);
      vectors++; if (n !== 61) begin miscompares++; $display("FAIL sat_relock: loss %0d got %0d ticks expected 61", i, n); end
    end
    vectors++; if (lock_errors !== 8'd255) begin miscompares++; $display("FAIL sat_final: got %0d expected 255", lock_errors); end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_delayed_edge();
    test_dropout();
`ifdef BX_COUNTER_EN
    test_bx_counter();
`endif
    test_reset_mid_lock();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bx_phase_tracker.md
BX_PHASE_TRACKER -- requirements
Module: bx_phase_tracker

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 16: consecutive good 40 MHz edges required to declare lock (range 2..255).
REQ-002 SHALL have parameter MAX_BX, default 3563: last bunch-crossing number before the BX counter wraps.
REQ-003 SHALL have port clock  in  1: single 160 MHz fast clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  in  1: reset, asynchronous, active-low.
REQ-005 SHALL have port clock40_sample  in  1: 40 MHz LHC clock, sampled as asynchronous data.
REQ-006 SHALL have port bc0  in  1: single-cycle orbit-reset request, synchronous to clock.
REQ-007 SHALL have port phase  out  2: fast-clock phase within the current BX (0..3).
REQ-008 SHALL have port frame_strobe  out  1: first fast cycle of each BX while locked.
REQ-009 SHALL have port locked  out  1: tracker in LOCKED state.
REQ-010 SHALL have port lock_errors  out  8: saturating count of lock losses.
REQ-011 SHALL have port bx_count  out  12: BX number within orbit (present only with BX_COUNTER_EN).

Function
REQ-012 SHALL pass clock40_sample through two synchroniser flops (s1, s2) plus one history flop (s3); edge = s2 AND NOT s3.
REQ-013 SHALL update phase as: edge -> 0; otherwise phase+1, wrapping 3 -> 0 (free-running in every state).
REQ-014 SHALL classify edge with phase==3 as good; edge with phase!=3, or no edge with phase==3, as error.
REQ-015 SHALL implement FSM states UNLOCKED, ACQUIRE, LOCKED.
REQ-016 UNLOCKED: any edge -> ACQUIRE, good counter cleared; no errors counted.
REQ-017 ACQUIRE: good edge increments good counter; good edge with counter == LOCK_COUNT-2 -> LOCKED; error -> UNLOCKED.
REQ-018 LOCKED: error -> UNLOCKED and lock_errors increments, saturating at 255; good edges hold state.
REQ-019 SHALL drive locked = (state==LOCKED), frame_strobe = (state==LOCKED AND phase==0), both from registers (no input-to-output combinational path).
REQ-020 SHALL register bc0 into a pending flag; flag clears at the next BX boundary (locked AND phase==3).
REQ-021 SHALL, at each BX boundary, load bx_count with 0 if bc0 or pending flag set, else 0 if bx_count==MAX_BX, else bx_count+1.
REQ-022 SHALL hold bx_count and keep any pending bc0 while not LOCKED.
REQ-023 SHALL treat bc0 coincident with a boundary as applied at that boundary (count -> 0, pending not set).

Reset
REQ-024 reset_n low SHALL asynchronously force: s1/s2/s3=0, phase=0, state=UNLOCKED, good counter=0, locked=0, frame_strobe=0, lock_errors=0, bc0 pending=0, bx_count=0.
REQ-025 Release SHALL be synchronous to clock; first edge detection occurs no earlier than 3 cycles after release.
REQ-026 Reset mid-lock SHALL drop locked immediately and clear lock_errors; re-lock requires full acquisition.

Configuration
REQ-027 Macro BX_COUNTER_EN defined: bc0 pending logic and bx_count port/counter compiled in per REQ-020..023.
REQ-028 Macro BX_COUNTER_EN undefined: bx_count port, counter and pending flag absent; bc0 port present and ignored; all other behaviour unchanged.

Verification
REQ-029 Clean 40 MHz in-phase with 160 MHz, LOCK_COUNT=16 -> locked rises after 16th edge; frame_strobe every 4 cycles thereafter; lock_errors=0.
REQ-030 Once locked, delay one clock40_sample rising edge by one fast cycle -> locked falls next cycle, lock_errors=1; re-lock after 16 further good edges.
REQ-031 Drop clock40_sample for 10 fast cycles while locked -> error at first phase==3 without edge; unlock; lock_errors increments once only.
REQ-032 Force 300 lock losses -> lock_errors saturates at 255.
REQ-033 (BX_COUNTER_EN) locked, bc0 pulsed mid-BX -> bx_count 0 at next boundary, then counts 1..3563, wraps to 0 after 3564 strobes; bc0 on boundary cycle -> 0 at that boundary.
REQ-034 Assert reset_n low for 1 cycle while locked with bx_count=100 -> all outputs 0 asynchronously; locked returns only after full acquisition.
